// File: rtl/wb_timer_multi_if.sv
// Wishbone classic-pipelined bus bundle for wb_timer_multi; signal names follow the peripheral's port list.
interface wb_timer_multi_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic [31:0] wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
    input  wb_ack_o, wb_stall_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
    output wb_ack_o, wb_stall_o, wb_data_o
  );
endinterface

// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone timer: shared prescaler, NUM_CH compare channels (periodic/one-shot),
// sticky W1C interrupt status gated by a per-channel enable onto a single irq_o line.
module wb_timer_multi #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  wb_timer_multi_if.slave  wb,
  output logic             irq_o,
  output logic             tick_o
);

  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]         irq_status_q, irq_status_d;
  logic [NUM_CH-1:0]         irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]         en_q, en_d;
  logic [NUM_CH-1:0]         oneshot_q, oneshot_d;
  logic [CNT_WIDTH-1:0]      cmp_q [NUM_CH];
  logic [CNT_WIDTH-1:0]      cmp_d [NUM_CH];
  logic [CNT_WIDTH-1:0]      cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0]      cnt_d [NUM_CH];
  logic                      ack_q, ack_d;
  logic [31:0]               rdata_q, rdata_d;

  logic                      accept, wr, tick, ch_wr;
  logic [29:0]               woff;
  logic                      in_win, glb_hit;
  logic [3:0]                grp;
  logic [1:0]                sub;
  logic [31:0]               rd_val, ctrl_new;
  logic [NUM_CH-1:0]         set_mask, clr_mask;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Word-granular offset; anything at or beyond 256 B from the base lands outside the window.
  assign woff    = wb.wb_addr_i[31:2] - BASE_ADDR[31:2];
  assign in_win  = (woff[29:6] == '0);
  assign grp     = woff[5:2];
  assign sub     = woff[1:0];
  assign glb_hit = in_win && (grp == 4'd0);

  always_comb begin
    rd_val = '0;
    if (glb_hit) begin
      case (sub)
        2'd0:    rd_val = 32'(prescale_q);
        2'd1:    rd_val = 32'(irq_status_q);
        2'd2:    rd_val = 32'(irq_en_q);
        default: rd_val = '0;
      endcase
    end
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (in_win && (32'(grp) == n + 1)) begin
        case (sub)
          2'd0:    rd_val = {30'b0, oneshot_q[n], en_q[n]};
          2'd1:    rd_val = 32'(cmp_q[n]);
          2'd2:    rd_val = 32'(cnt_q[n]);
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_comb begin
    accept       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    wr           = accept & wb.wb_we_i;
    tick         = (pcnt_q == prescale_q);
    ack_d        = accept;
    rdata_d      = (accept && !wb.wb_we_i) ? rd_val : rdata_q;
    prescale_d   = prescale_q;
    pcnt_d       = tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
    irq_en_d     = irq_en_q;
    en_d         = en_q;
    oneshot_d    = oneshot_q;
    set_mask     = '0;
    clr_mask     = '0;
    ctrl_new     = '0;
    ch_wr        = 1'b0;

    if (wr && glb_hit) begin
      case (sub)
        2'd0: begin
          prescale_d = PRESCALE_WIDTH'(lane_merge(32'(prescale_q), wb.wb_data_i, wb.wb_sel_i));
          pcnt_d     = '0;
        end
        2'd1:    clr_mask = NUM_CH'(lane_merge('0, wb.wb_data_i, wb.wb_sel_i));
        2'd2:    irq_en_d = NUM_CH'(lane_merge(32'(irq_en_q), wb.wb_data_i, wb.wb_sel_i));
        default: ;
      endcase
    end

    for (int unsigned n = 0; n < NUM_CH; n++) begin
      cmp_d[n] = cmp_q[n];
      cnt_d[n] = cnt_q[n];
      ch_wr    = wr && in_win && (32'(grp) == n + 1);
      // A CNT write on a tick edge replaces the count and skips event evaluation entirely.
      if (tick && en_q[n] && !(ch_wr && sub == 2'd2)) begin
        if (cnt_q[n] == cmp_q[n]) begin
          cnt_d[n]    = '0;
          set_mask[n] = 1'b1;
          if (oneshot_q[n]) en_d[n] = 1'b0;
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
        end
      end
      if (ch_wr) begin
        case (sub)
          2'd0: begin
            ctrl_new     = lane_merge({30'b0, oneshot_q[n], en_q[n]}, wb.wb_data_i, wb.wb_sel_i);
            en_d[n]      = ctrl_new[0];
            oneshot_d[n] = ctrl_new[1];
          end
          2'd1:    cmp_d[n] = CNT_WIDTH'(lane_merge(32'(cmp_q[n]), wb.wb_data_i, wb.wb_sel_i));
          2'd2:    cnt_d[n] = CNT_WIDTH'(lane_merge(32'(cnt_q[n]), wb.wb_data_i, wb.wb_sel_i));
          default: ;
        endcase
      end
    end

    irq_status_d = (irq_status_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q   <= '0;
      pcnt_q       <= '0;
      irq_status_q <= '0;
      irq_en_q     <= '0;
      en_q         <= '0;
      oneshot_q    <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cmp_q[n] <= '0;
        cnt_q[n] <= '0;
      end
    end else begin
      prescale_q   <= prescale_d;
      pcnt_q       <= pcnt_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
      en_q         <= en_d;
      oneshot_q    <= oneshot_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      cmp_q        <= cmp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_stall_o = 1'b0;
  assign wb.wb_data_o  = rdata_q;
  assign irq_o         = |(irq_status_q & irq_en_q);
  // Registers all reset to zero, which would otherwise read as a tick during reset.
  assign tick_o        = tick & ~rst;

endmodule

// File: tb/tb_wb_timer_multi.sv
// Directed bench for wb_timer_multi: bus reads are scored against a queue of expected values.
module tb_wb_timer_multi;
  localparam logic [31:0] B = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  logic irq, tick;
  always #5 clk = ~clk;

  wb_timer_multi_if bus();

  wb_timer_multi #(
    .BASE_ADDR(B), .NUM_CH(4), .CNT_WIDTH(32), .PRESCALE_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .wb(bus), .irq_o(irq), .tick_o(tick)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc_cnt  = 0;
  logic        irq_at_accept;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, output logic [31:0] rd);
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    bus.wb_we_i   = we;
    bus.wb_addr_i = addr;
    bus.wb_data_i = data;
    bus.wb_sel_i  = sel;
    check("ack_idle", 32'(bus.wb_ack_o), 32'd0);
    @(posedge clk); #1;
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    bus.wb_we_i   = 1'b0;
    irq_at_accept = irq;
    check("ack_latency", 32'(bus.wb_ack_o), 32'd1);
    rd = bus.wb_data_o;
    @(posedge clk); #1;
    check("ack_single", 32'(bus.wb_ack_o), 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_cycle(1'b1, addr, data, sel, dummy);
  endtask

  task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    wb_cycle(1'b0, addr, 32'h0, 4'hF, rd);
    check(tag_q.pop_front(), rd, exp_q.pop_front());
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("tick_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_irq(output int unsigned t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin
        seen = 1'b1;
        t    = cyc_cnt;
        break;
      end
    end
    check("irq_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned t_prev, t_now, t1, t2, t0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_addr_i = '0; bus.wb_data_i = '0; bus.wb_sel_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", bus.wb_data_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Every register reads zero out of reset
    wb_read(B + 32'h00, 32'd0, "rst_prescale");
    wb_read(B + 32'h04, 32'd0, "rst_status");
    wb_read(B + 32'h08, 32'd0, "rst_irq_en");
    for (int n = 0; n < 4; n++) begin
      wb_read(B + 32'h10 + 32'(16 * n), 32'd0, "rst_ctrl");
      wb_read(B + 32'h14 + 32'(16 * n), 32'd0, "rst_cmp");
      wb_read(B + 32'h18 + 32'(16 * n), 32'd0, "rst_cnt");
    end

    // Periodic CH0: PRESCALE=3, CMP=4
    wb_write(B + 32'h08, 32'h1, 4'hF);
    wb_write(B + 32'h14, 32'd4, 4'hF);
    wb_write(B + 32'h00, 32'd3, 4'hF);
    wb_read(B + 32'h00, 32'd3, "prescale_rb");
    wait_tick();
    wb_write(B + 32'h10, 32'h1, 4'hF);
    t_prev = 0;
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      t_now = cyc_cnt;
      if (k > 1) check("tick_period", 32'(t_now - t_prev), 32'd4);
      t_prev = t_now;
      wb_read(B + 32'h18, 32'(k % 5), "ch0_cnt_seq");
    end
    check("ch0_irq_high", 32'(irq), 32'd1);
    wb_read(B + 32'h04, 32'h1, "ch0_status");
    wb_write(B + 32'h04, 32'h1, 4'hF);
    wait_irq(t1);
    wb_write(B + 32'h04, 32'h1, 4'hF);
    wait_irq(t2);
    check("event_period", 32'(t2 - t1), 32'd20);
    wb_write(B + 32'h10, 32'h0, 4'hF);
    wb_write(B + 32'h04, 32'hF, 4'hF);
    wb_read(B + 32'h04, 32'h0, "status_cleared");

    // One-shot CH1 at PRESCALE=0
    wb_write(B + 32'h00, 32'd0, 4'hF);
    wb_write(B + 32'h08, 32'h2, 4'hF);
    wb_write(B + 32'h24, 32'd2, 4'hF);
    wb_write(B + 32'h20, 32'h3, 4'hF);
    t0 = cyc_cnt - 1;
    wait_irq(t1);
    check("oneshot_latency", 32'(t1 - t0), 32'd3);
    wb_read(B + 32'h20, 32'h2, "oneshot_ctrl");
    wb_read(B + 32'h28, 32'h0, "oneshot_cnt");
    wb_read(B + 32'h04, 32'h2, "oneshot_status");
    wb_write(B + 32'h04, 32'h2, 4'hF);

    // W1C colliding with an event every clock (CMP=0): set wins
    wb_write(B + 32'h08, 32'h1, 4'hF);
    wb_write(B + 32'h14, 32'd0, 4'hF);
    wb_write(B + 32'h10, 32'h1, 4'hF);
    wb_write(B + 32'h04, 32'h1, 4'hF);
    check("w1c_vs_event_irq", 32'(irq_at_accept), 32'd1);
    wb_write(B + 32'h10, 32'h0, 4'hF);
    wb_write(B + 32'h04, 32'h1, 4'hF);
    check("w1c_clear_irq", 32'(irq_at_accept), 32'd0);
    wb_read(B + 32'h04, 32'h0, "w1c_status");
    check("irq_dropped", 32'(irq), 32'd0);

    // CH2 wrap from all-ones with CMP=5, PRESCALE=15
    wb_write(B + 32'h00, 32'd15, 4'hF);
    wb_write(B + 32'h34, 32'd5, 4'hF);
    wb_write(B + 32'h38, 32'hFFFF_FFFF, 4'hF);
    wait_tick();
    wb_read(B + 32'h38, 32'hFFFF_FFFF, "disabled_cnt_holds");
    wb_write(B + 32'h30, 32'h1, 4'hF);
    wait_tick();
    wb_read(B + 32'h38, 32'h0, "wrap_cnt");
    wb_read(B + 32'h04, 32'h0, "wrap_no_event");
    repeat (5) wait_tick();
    wb_read(B + 32'h38, 32'd5, "wrap_cnt5");
    wb_read(B + 32'h04, 32'h0, "wrap_pre_event");
    wait_tick();
    wb_read(B + 32'h38, 32'h0, "wrap_cnt_reset");
    wb_read(B + 32'h04, 32'h4, "wrap_event");

    // Byte lanes and address decode
    wb_write(B + 32'h44, 32'h1122_3344, 4'hF);
    wb_write(B + 32'h44, 32'hAABB_CCDD, 4'b0001);
    wb_read(B + 32'h44, 32'h1122_33DD, "byte_lane");
    wb_read(B + 32'hFC, 32'h0, "unmapped_fc");
    wb_write(B + 32'h1C, 32'h5A5A_5A5A, 4'hF);
    wb_read(B + 32'h1C, 32'h0, "unmapped_1c");
    wb_read(B + 32'h50, 32'h0, "no_ch4");
    wb_write(B + 32'h100, 32'd7, 4'hF);
    wb_read(B + 32'h00, 32'd15, "out_of_window_write");
    wb_read(32'h0000_0000, 32'h0, "out_of_window_read");

    // Reset mid-transaction and mid-count
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_addr_i = B + 32'h44; bus.wb_sel_i = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_ack", 32'(bus.wb_ack_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    wb_read(B + 32'h00, 32'h0, "rst2_prescale");
    wb_read(B + 32'h44, 32'h0, "rst2_cmp3");
    wb_read(B + 32'h30, 32'h0, "rst2_ctrl2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
